// File: rtl/fp_mul_pkg.sv
// Shared constants and stage types for the binary32 multiplier normalise/round back end.
package fp_mul_pkg;

  localparam int FP_XLEN   = 32;
  localparam int FP_MANT_W = 48;
  localparam int FP_EXP_W  = 10;
  localparam int FP_FRAC_W = 23;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 2 * FP_BIAS + 1;

  localparam logic [31:0] FP_QNAN      = 32'h7FC00000;
  localparam logic [31:0] FP_MAX_FINITE = 32'h7F7FFFFF;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } round_mode_e;

  // Normalised product held between the two pipeline stages
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
    logic                 guard;
    logic                 sticky;
    logic                 nan;
    logic                 inf;
    logic                 zero;
    logic [1:0]           mode;
  } fp_norm_t;

endpackage

// File: rtl/fp_mul_norm_round_inc.sv
// Rounding increment decision: applies the selected rounding mode to the normalised fraction.
module fp_round_inc
  import fp_mul_pkg::*;
(
  input  logic                 sign,
  input  logic [FP_FRAC_W-1:0] frac,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [1:0]           mode,
  output logic [FP_FRAC_W-1:0] frac_rnd,
  output logic                 carry,
  output logic                 inexact
);

  logic lost;
  logic inc;

  assign lost = guard | sticky;

  always_comb begin
    inc = 1'b0;
    case (mode)
      RTZ:     inc = 1'b0;
      RUP:     inc = !sign && lost;
      RDN:     inc = sign && lost;
      default: inc = guard && (sticky || frac[0]);
    endcase
  end

  // A carry out of the fraction leaves it all zero, i.e. the next power of two
  assign {carry, frac_rnd} = {1'b0, frac} + (FP_FRAC_W + 1)'(inc);
  assign inexact = lost;

endmodule

// File: rtl/fp_mul_norm_round.sv
// Normalise/round back end of the binary32 multiplier: two-stage valid/ready pipeline.
// Define FP_MUL_ROUND_MODE_EN to add the rnd_mode port (RNE/RTZ/RUP/RDN); otherwise RNE only.
module fp_mul_norm_round
  import fp_mul_pkg::*;
#(
  parameter int XLEN   = FP_XLEN,
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FP_MUL_ROUND_MODE_EN
  input  logic [1:0]        rnd_mode,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_nan,
  input  logic              in_inf,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_exception,
  output logic              out_inexact
);

  logic       s1_valid;
  logic       s1_en;
  logic       s2_en;
  logic [1:0] mode_in;
  fp_norm_t   s1_d;
  fp_norm_t   s1_q;

`ifdef FP_MUL_ROUND_MODE_EN
  assign mode_in = rnd_mode;
`else
  assign mode_in = RNE;
`endif

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = s1_en;

  // The 24x24 product lies in [1,4): bit 47 set means the value is >= 2
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
    s1_d.zero = in_zero;
    s1_d.mode = mode_in;
    if (in_mant[MANT_W-1]) begin
      s1_d.frac   = in_mant[46:24];
      s1_d.guard  = in_mant[23];
      s1_d.sticky = |in_mant[22:0];
      s1_d.exp    = in_exp + EXP_W'(1);
    end else begin
      s1_d.frac   = in_mant[45:23];
      s1_d.guard  = in_mant[22];
      s1_d.sticky = |in_mant[21:0];
      s1_d.exp    = in_exp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic [FP_FRAC_W-1:0] frac_rnd;
  logic                 carry;
  logic                 inexact;
  logic [EXP_W-1:0]     exp_rnd;
  logic                 exp_ovf;
  logic                 exp_unf;
  logic                 ovf_to_inf;
  logic [XLEN-1:0]      result_d;
  logic                 ovf_d;
  logic                 unf_d;
  logic                 exc_d;
  logic                 inx_d;

  fp_round_inc u_round (
    .sign     (s1_q.sign),
    .frac     (s1_q.frac),
    .guard    (s1_q.guard),
    .sticky   (s1_q.sticky),
    .mode     (s1_q.mode),
    .frac_rnd (frac_rnd),
    .carry    (carry),
    .inexact  (inexact)
  );

  // Exponent is two's complement; the sign bit marks values below zero
  assign exp_rnd = s1_q.exp + EXP_W'(carry);
  assign exp_ovf = !exp_rnd[EXP_W-1] && (exp_rnd >= EXP_W'(FP_EXP_MAX));
  assign exp_unf = exp_rnd[EXP_W-1] || (exp_rnd == '0);

  // Directed modes only reach infinity when rounding toward the result's sign
  always_comb begin
    ovf_to_inf = 1'b1;
    case (s1_q.mode)
      RTZ:     ovf_to_inf = 1'b0;
      RUP:     ovf_to_inf = !s1_q.sign;
      RDN:     ovf_to_inf = s1_q.sign;
      default: ovf_to_inf = 1'b1;
    endcase
  end

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    exc_d    = 1'b0;
    inx_d    = 1'b0;
    if (s1_q.nan) begin
      result_d = FP_QNAN;
      exc_d    = 1'b1;
    end else if (s1_q.inf) begin
      result_d = {s1_q.sign, 8'hFF, 23'h0};
    end else if (s1_q.zero) begin
      result_d = {s1_q.sign, 31'h0};
    end else if (exp_ovf) begin
      result_d = ovf_to_inf ? {s1_q.sign, 8'hFF, 23'h0}
                            : {s1_q.sign, FP_MAX_FINITE[30:0]};
      ovf_d    = 1'b1;
      inx_d    = 1'b1;
    end else if (exp_unf) begin
      result_d = {s1_q.sign, 31'h0};
      unf_d    = 1'b1;
      inx_d    = 1'b1;
    end else begin
      result_d = {s1_q.sign, exp_rnd[7:0], frac_rnd};
      inx_d    = inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_exception <= 1'b0;
      out_inexact   <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result    <= result_d;
        out_overflow  <= ovf_d;
        out_underflow <= unf_d;
        out_exception <= exc_d;
        out_inexact   <= inx_d;
      end
    end
  end

endmodule
